ddma_arbiter: RTL and testbench

- Shares one DDMA engine between NUM_REQ requesters, for example several TCD channels or a CPU configuration port.
- Each requester presents an address, a byte count and a request. The arbiter grants round-robin and drives the DDMA address, size and command lines.
- It tracks the DDMA status handshake, signals per-requester completion, and aborts stalled transfers with a watchdog.
- It sits between the requesters and the ddma block, replacing their direct connection.

---
 rtl/ddma_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/ddma_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ddma_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddma_arb_pkg.sv
// ddma_arb_pkg
// Shared types and defaults for the DDMA arbiter slice.
//   ddma_arb_state_t       : arbiter FSM states
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit per transfer
package ddma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } ddma_arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational rotating-priority select. The search starts one position
// after the last owner and wraps, so the previous owner is considered last.
// Ports:
//   req_i   : request vector
//   last_i  : index of the previous owner
//   grant_o : one-hot winner (zero when no request)
//   idx_o   : binary index of the winner
//   valid_o : at least one request present
module rr_arbiter import ddma_arb_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       valid_o
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam logic [IDXW:0] NUM_REQ_W = (IDXW+1)'(NUM_REQ);

  logic [IDXW:0]   sum;
  logic [IDXW-1:0] cand;

  // Walk the candidates last+1 .. last+NUM_REQ (mod NUM_REQ); the first
  // requester found wins. The extra sum bit keeps the wrap subtraction exact
  // for non-power-of-two requester counts.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, last_i} + (IDXW+1)'(off);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      cand = sum[IDXW-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/ddma_arbiter.sv
// ddma_arbiter
// Shares one DDMA engine between NUM_REQ requesters with round-robin grants,
// follows the DDMA busy handshake, pulses per-requester completion and aborts
// transfers that exceed TIMEOUT_CYCLES.
// Ports:
//   clock, reset      : clock and synchronous active-low reset
//   req_in            : per-requester request level
//   addr_in/nbytes_in : packed per-requester address / byte count
//   grant_out         : one-hot current owner
//   done_out          : one-cycle completion (or abort) pulse to the owner
//   err_clr_in        : clears the sticky timeout flag
//   err_out/err_id_out: sticky timeout flag and the requester that caused it
//   dma_addr_out, dma_nbytes_out, dma_cmd_out : to the DDMA engine
//   dma_status_in     : DDMA busy indication
module ddma_arbiter import ddma_arb_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] nbytes_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic [NUM_REQ-1:0]            done_out,
  input  logic                          err_clr_in,
  output logic                          err_out,
  output logic [$clog2(NUM_REQ)-1:0]    err_id_out,
  output logic [DATA_WIDTH-1:0]         dma_addr_out,
  output logic [DATA_WIDTH-1:0]         dma_nbytes_out,
  output logic                          dma_cmd_out,
  input  logic                          dma_status_in
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int WDW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  ddma_arb_state_t       state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] nbytes_q, nbytes_d;
  logic [IDXW-1:0]       owner_q, owner_d;
  logic [IDXW-1:0]       last_q, last_d;
  logic [IDXW-1:0]       err_id_q, err_id_d;
  logic                  err_q, err_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic                  timeout;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDXW-1:0]       arb_idx;
  logic                  arb_valid;

  logic [DATA_WIDTH-1:0] addr_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0] nbytes_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]   = addr_in[g*DATA_WIDTH +: DATA_WIDTH];
    assign nbytes_arr[g] = nbytes_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i   (req_in),
    .last_i  (last_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Next-state logic. IDLE spends one cycle latching the winner and a second
  // deciding between ISSUE and the zero-length shortcut, which is why a grant
  // is visible one cycle before the command. done_out is raised on every
  // entry into DONE so it coincides with that one-cycle state; a timeout also
  // enters DONE, so aborted requesters still get their pulse.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    addr_d   = addr_q;
    nbytes_d = nbytes_q;
    owner_d  = owner_q;
    last_d   = last_q;
    err_d    = err_q;
    err_id_d = err_id_q;
    wd_d     = wd_q;
    timeout  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_q == '0) begin
          if (arb_valid) begin
            grant_d  = arb_grant;
            owner_d  = arb_idx;
            addr_d   = addr_arr[arb_idx];
            nbytes_d = nbytes_arr[arb_idx];
          end
        end else begin
          wd_d = '0;
          if (nbytes_q != '0) begin
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        wd_d = wd_q + WDW'(1);
        if (wd_q == WD_LAST) begin
          timeout = 1'b1;
          state_d = DONE;
        end else if (dma_status_in) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        wd_d = wd_q + WDW'(1);
        if (wd_q == WD_LAST) begin
          timeout = 1'b1;
          state_d = DONE;
        end else if (!dma_status_in) begin
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        last_d  = owner_q;
        wd_d    = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == DONE) begin
      done_d[owner_q] = 1'b1;
    end

    // A fresh timeout outranks a simultaneous clear.
    if (timeout) begin
      err_d    = 1'b1;
      err_id_d = owner_q;
    end else if (err_clr_in) begin
      err_d    = 1'b0;
      err_id_d = '0;
    end
  end

  // State and output registers. The pointer resets to the last requester so
  // requester 0 is first in line after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      addr_q   <= '0;
      nbytes_q <= '0;
      owner_q  <= '0;
      last_q   <= IDXW'(NUM_REQ - 1);
      err_q    <= 1'b0;
      err_id_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      nbytes_q <= nbytes_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
      wd_q     <= wd_d;
    end
  end

  assign grant_out      = grant_q;
  assign done_out       = done_q;
  assign err_out        = err_q;
  assign err_id_out     = err_id_q;
  assign dma_addr_out   = addr_q;
  assign dma_nbytes_out = nbytes_q;
  assign dma_cmd_out    = (state_q == ISSUE);

endmodule

// File: tb/tb_ddma_arbiter.sv
// tb_ddma_arbiter
// Directed bench for ddma_arbiter with four requesters and an eight-cycle
// watchdog. A small DDMA model answers dma_cmd_out with a busy window.
module tb_ddma_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   reqIn;
  logic [127:0] addrIn;
  logic [127:0] nbytesIn;
  logic         errClr;
  logic         dmaStatus = 1'b0;
  logic [3:0]   grantOut;
  logic [3:0]   doneOut;
  logic         errOut;
  logic [1:0]   errIdOut;
  logic [31:0]  dmaAddr;
  logic [31:0]  dmaNbytes;
  logic         dmaCmd;

  int assertions = 0;
  int failures   = 0;

  bit modelEnable  = 1'b0;
  int modelBusyLen = 5;
  int modelCount   = 0;

  ddma_arbiter #(
    .NUM_REQ        (4),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_in         (reqIn),
    .addr_in        (addrIn),
    .nbytes_in      (nbytesIn),
    .grant_out      (grantOut),
    .done_out       (doneOut),
    .err_clr_in     (errClr),
    .err_out        (errOut),
    .err_id_out     (errIdOut),
    .dma_addr_out   (dmaAddr),
    .dma_nbytes_out (dmaNbytes),
    .dma_cmd_out    (dmaCmd),
    .dma_status_in  (dmaStatus)
  );

  always #5 clock = ~clock;

  // DDMA model: raises busy in the cycle it first sees the command and holds
  // it for modelBusyLen clock edges. Disabling it forces busy low forever.
  always @(negedge clock) begin
    if (!modelEnable) begin
      dmaStatus  = 1'b0;
      modelCount = 0;
    end else if (modelCount > 0) begin
      modelCount = modelCount - 1;
      if (modelCount == 0) dmaStatus = 1'b0;
    end else if (dmaCmd) begin
      dmaStatus  = 1'b1;
      modelCount = modelBusyLen;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Hold reset for a few edges and confirm every output is cleared.
  task automatic test_reset();
    reset = 1'b0; reqIn = '0; addrIn = '0; nbytesIn = '0; errClr = 1'b0;
    tick(3);
    assertions++; if (grantOut !== 4'b0000) begin failures++; $display("[TB] FAIL reset_grant: got %b expected 0000", grantOut); end
    assertions++; if (doneOut !== 4'b0000) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0000", doneOut); end
    assertions++; if (dmaCmd !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd: got %b expected 0", dmaCmd); end
    assertions++; if (errOut !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", errOut); end
    assertions++; if (errIdOut !== 2'd0) begin failures++; $display("[TB] FAIL reset_err_id: got %0d expected 0", errIdOut); end
    assertions++; if (dmaAddr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0", dmaAddr); end
    assertions++; if (dmaNbytes !== 32'h0) begin failures++; $display("[TB] FAIL reset_nbytes: got %h expected 0", dmaNbytes); end
    reset = 1'b1;
    tick(1);
  endtask

  // All four requesters held high: grants must rotate 0,1,2,3,0,1,2,3 with
  // at most one grant bit set at any time.
  task automatic test_round_robin();
    logic [3:0] prevGrant = 4'b0000;
    logic [3:0] expected;
    int grantCount = 0;
    int doneCount  = 0;
    bit overlap    = 1'b0;
    addrIn = '0; nbytesIn = '0;
    for (int i = 0; i < 4; i++) begin
      addrIn[i*32 +: 32]   = 32'h1000 + 32'(i * 16);
      nbytesIn[i*32 +: 32] = 32'(4 + i);
    end
    modelEnable = 1'b1; modelBusyLen = 2;
    reqIn = 4'b1111;
    for (int cyc = 0; cyc < 300 && doneCount < 8; cyc++) begin
      tick(1);
      if ($countones(grantOut) > 1) overlap = 1'b1;
      if (grantOut != 4'b0000 && prevGrant == 4'b0000) begin
        expected = 4'b0001 << (grantCount % 4);
        assertions++; if (grantOut !== expected) begin failures++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", grantCount, grantOut, expected); end
        grantCount++;
      end
      if (doneOut != 4'b0000) begin
        expected = 4'b0001 << (doneCount % 4);
        assertions++; if (doneOut !== expected) begin failures++; $display("[TB] FAIL rr_done_%0d: got %b expected %b", doneCount, doneOut, expected); end
        doneCount++;
        if (doneCount == 8) reqIn = 4'b0000;
      end
      prevGrant = grantOut;
    end
    assertions++; if (doneCount != 8) begin failures++; $display("[TB] FAIL rr_done_count: got %0d expected 8", doneCount); end
    assertions++; if (grantCount != 8) begin failures++; $display("[TB] FAIL rr_grant_count: got %0d expected 8", grantCount); end
    assertions++; if (overlap) begin failures++; $display("[TB] FAIL rr_overlap: got 1 expected 0"); end
    tick(1);
    assertions++; if (grantOut !== 4'b0000) begin failures++; $display("[TB] FAIL rr_idle_grant: got %b expected 0000", grantOut); end
  endtask

  // Requester 1 alone, 16 bytes at 0x100, five busy cycles.
  task automatic test_single();
    int cnt;
    addrIn = '0; nbytesIn = '0;
    addrIn[32 +: 32]   = 32'h100;
    nbytesIn[32 +: 32] = 32'd16;
    modelEnable = 1'b1; modelBusyLen = 5;
    reqIn = 4'b0010;
    tick(1);
    assertions++; if (grantOut !== 4'b0010) begin failures++; $display("[TB] FAIL single_grant: got %b expected 0010", grantOut); end
    assertions++; if (dmaCmd !== 1'b0) begin failures++; $display("[TB] FAIL single_cmd_early: got %b expected 0", dmaCmd); end
    assertions++; if (dmaAddr !== 32'h100) begin failures++; $display("[TB] FAIL single_addr: got %h expected 100", dmaAddr); end
    assertions++; if (dmaNbytes !== 32'd16) begin failures++; $display("[TB] FAIL single_nbytes: got %0d expected 16", dmaNbytes); end
    tick(1);
    assertions++; if (dmaCmd !== 1'b1) begin failures++; $display("[TB] FAIL single_cmd: got %b expected 1", dmaCmd); end
    tick(1);
    assertions++; if (dmaCmd !== 1'b0) begin failures++; $display("[TB] FAIL single_cmd_drop: got %b expected 0", dmaCmd); end
    cnt = 3;
    while (doneOut == 4'b0000 && cnt < 40) begin
      tick(1);
      cnt++;
    end
    assertions++; if (cnt != 8) begin failures++; $display("[TB] FAIL single_done_latency: got %0d expected 8", cnt); end
    assertions++; if (doneOut !== 4'b0010) begin failures++; $display("[TB] FAIL single_done: got %b expected 0010", doneOut); end
    assertions++; if (grantOut !== 4'b0010) begin failures++; $display("[TB] FAIL single_grant_held: got %b expected 0010", grantOut); end
    reqIn = 4'b0000;
    tick(1);
    assertions++; if (doneOut !== 4'b0000) begin failures++; $display("[TB] FAIL single_done_pulse: got %b expected 0000", doneOut); end
    assertions++; if (grantOut !== 4'b0000) begin failures++; $display("[TB] FAIL single_grant_clear: got %b expected 0000", grantOut); end
  endtask

  // Requester 2 with a zero byte count completes without any DDMA command.
  task automatic test_zero_length();
    bit cmdSeen = 1'b0;
    addrIn = '0; nbytesIn = '0;
    addrIn[64 +: 32] = 32'h200;
    reqIn = 4'b0100;
    tick(1);
    if (dmaCmd) cmdSeen = 1'b1;
    assertions++; if (grantOut !== 4'b0100) begin failures++; $display("[TB] FAIL zero_grant: got %b expected 0100", grantOut); end
    assertions++; if (dmaAddr !== 32'h200) begin failures++; $display("[TB] FAIL zero_addr: got %h expected 200", dmaAddr); end
    tick(1);
    if (dmaCmd) cmdSeen = 1'b1;
    assertions++; if (doneOut !== 4'b0100) begin failures++; $display("[TB] FAIL zero_done: got %b expected 0100", doneOut); end
    reqIn = 4'b0000;
    tick(1);
    if (dmaCmd) cmdSeen = 1'b1;
    assertions++; if (doneOut !== 4'b0000) begin failures++; $display("[TB] FAIL zero_done_pulse: got %b expected 0000", doneOut); end
    assertions++; if (cmdSeen) begin failures++; $display("[TB] FAIL zero_cmd: got 1 expected 0"); end
  endtask

  // Reset asserted while BUSY; the pointer must return to requester 0.
  task automatic test_mid_reset();
    addrIn = '0; nbytesIn = '0;
    for (int i = 0; i < 4; i++) nbytesIn[i*32 +: 32] = 32'd8;
    addrIn[32 +: 32] = 32'h500;
    modelEnable = 1'b1; modelBusyLen = 5;
    reqIn = 4'b0010;
    tick(1);
    assertions++; if (grantOut !== 4'b0010) begin failures++; $display("[TB] FAIL mreset_grant: got %b expected 0010", grantOut); end
    tick(3);
    reset = 1'b0; modelEnable = 1'b0;
    tick(1);
    assertions++; if (dmaCmd !== 1'b0) begin failures++; $display("[TB] FAIL mreset_cmd: got %b expected 0", dmaCmd); end
    assertions++; if (grantOut !== 4'b0000) begin failures++; $display("[TB] FAIL mreset_grant_clear: got %b expected 0000", grantOut); end
    assertions++; if (doneOut !== 4'b0000) begin failures++; $display("[TB] FAIL mreset_done: got %b expected 0000", doneOut); end
    reset = 1'b1; reqIn = 4'b1111;
    tick(1);
    assertions++; if (grantOut !== 4'b0001) begin failures++; $display("[TB] FAIL mreset_priority: got %b expected 0001", grantOut); end
    reset = 1'b0; reqIn = 4'b0000;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  // DDMA never answers: abort after eight ISSUE cycles, then clear the flag.
  task automatic test_timeout();
    int cnt = 0;
    int cmdCount = 0;
    addrIn = '0; nbytesIn = '0;
    addrIn[96 +: 32]   = 32'h400;
    nbytesIn[96 +: 32] = 32'd32;
    modelEnable = 1'b0;
    reqIn = 4'b1000;
    while (doneOut == 4'b0000 && cnt < 40) begin
      tick(1);
      cnt++;
      if (dmaCmd) cmdCount++;
    end
    assertions++; if (cmdCount != 8) begin failures++; $display("[TB] FAIL tmo_cmd_cycles: got %0d expected 8", cmdCount); end
    assertions++; if (cnt != 10) begin failures++; $display("[TB] FAIL tmo_latency: got %0d expected 10", cnt); end
    assertions++; if (doneOut !== 4'b1000) begin failures++; $display("[TB] FAIL tmo_done: got %b expected 1000", doneOut); end
    assertions++; if (errOut !== 1'b1) begin failures++; $display("[TB] FAIL tmo_err: got %b expected 1", errOut); end
    assertions++; if (errIdOut !== 2'd3) begin failures++; $display("[TB] FAIL tmo_err_id: got %0d expected 3", errIdOut); end
    reqIn = 4'b0000;
    tick(1);
    assertions++; if (errOut !== 1'b1) begin failures++; $display("[TB] FAIL tmo_err_sticky: got %b expected 1", errOut); end
    assertions++; if (doneOut !== 4'b0000) begin failures++; $display("[TB] FAIL tmo_done_pulse: got %b expected 0000", doneOut); end
    errClr = 1'b1;
    tick(1);
    errClr = 1'b0;
    assertions++; if (errOut !== 1'b0) begin failures++; $display("[TB] FAIL tmo_err_clr: got %b expected 0", errOut); end
    assertions++; if (errIdOut !== 2'd0) begin failures++; $display("[TB] FAIL tmo_err_id_clr: got %0d expected 0", errIdOut); end
  endtask

  // Requester 3 drops its request and changes its address while BUSY.
  task automatic test_withdrawn();
    int cnt;
    addrIn = '0; nbytesIn = '0;
    addrIn[96 +: 32]   = 32'h300;
    nbytesIn[96 +: 32] = 32'd64;
    modelEnable = 1'b1; modelBusyLen = 5;
    reqIn = 4'b1000;
    tick(1);
    assertions++; if (grantOut !== 4'b1000) begin failures++; $display("[TB] FAIL wd_grant: got %b expected 1000", grantOut); end
    tick(3);
    assertions++; if (dmaCmd !== 1'b0) begin failures++; $display("[TB] FAIL wd_busy_cmd: got %b expected 0", dmaCmd); end
    reqIn = 4'b0000;
    addrIn[96 +: 32]   = 32'hDEAD_BEEF;
    nbytesIn[96 +: 32] = 32'h99;
    cnt = 4;
    while (doneOut == 4'b0000 && cnt < 40) begin
      tick(1);
      cnt++;
    end
    assertions++; if (cnt != 8) begin failures++; $display("[TB] FAIL wd_done_latency: got %0d expected 8", cnt); end
    assertions++; if (doneOut !== 4'b1000) begin failures++; $display("[TB] FAIL wd_done: got %b expected 1000", doneOut); end
    assertions++; if (dmaAddr !== 32'h300) begin failures++; $display("[TB] FAIL wd_addr: got %h expected 300", dmaAddr); end
    assertions++; if (dmaNbytes !== 32'd64) begin failures++; $display("[TB] FAIL wd_nbytes: got %0d expected 64", dmaNbytes); end
    tick(1);
    assertions++; if (grantOut !== 4'b0000) begin failures++; $display("[TB] FAIL wd_grant_clear: got %b expected 0000", grantOut); end
  endtask

  // Run every scenario in order; the pointer state carried between them is
  // part of what each one expects.
  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_length();
    test_mid_reset();
    test_timeout();
    test_withdrawn();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
